// File: rtl/mips_pipeline_pkg.sv
// rtl/mips_pipeline_pkg.sv - shared hazard state encoding, register constants and pipeline control vectors
package mips_pipeline_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_ERROR    = 2'd2
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // One bit per pipeline-register control, in the order the top drives them.
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_bubble;
    logic mem_stall;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam hazard_ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam hazard_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam hazard_ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam hazard_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  // A load into $zero never produces a value the ID instruction could depend on.
  function automatic logic load_use_detect(
    input logic       dm_read,
    input logic [4:0] ex_wr,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       uses_rt
  );
    return dm_read && (ex_wr != REG_ZERO) &&
           ((ex_wr == id_rs) || (uses_rt && (ex_wr == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// rtl/hazard_sat_counter.sv - saturating event counter with synchronous clear
module hazard_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush/freeze sequencer for the 5-stage pipeline
// Performance counters are built only when HAZARD_PERF_COUNTERS_EN is defined.
module pipeline_hazard_controller
  import mips_pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             ID_rs,
  input  logic [4:0]             ID_rt,
  input  logic                   ID_uses_rt,
  input  logic [4:0]             EX_write_reg_1,
  input  logic                   EX_dm_read,
  input  logic                   EX_branch_taken,
  input  logic                   MEM_dm_access,
  input  logic                   dm_ready,
  output logic                   pc_write_enable,
  output logic                   IF_ID_write_enable,
  output logic                   IF_ID_flush,
  output logic                   ID_EX_flush,
  output logic                   EX_MEM_write_enable,
  output logic                   MEM_WB_bubble,
  output logic                   mem_stall,
  output logic                   mem_timeout_error,
  output logic [STALL_CNT_W-1:0] stall_cycle_count,
  output logic [STALL_CNT_W-1:0] flush_count
);

  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  hazard_state_t r_state;
  hazard_state_t w_next_state;
  logic [7:0]    r_wait_cnt;
  logic [7:0]    w_next_wait_cnt;
  logic          r_timeout_error;
  logic          w_freeze;
  logic          w_load_use;
  logic          w_branch_eff;
  logic          w_load_use_eff;
  hazard_ctrl_t  w_ctrl;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= HZ_RUN;
      r_wait_cnt      <= 8'd0;
      r_timeout_error <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
      if ((r_state != HZ_ERROR) && (w_next_state == HZ_ERROR)) begin
        r_timeout_error <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_freeze        = 1'b0;
    case (r_state)
      HZ_RUN: begin
        if (MEM_dm_access && !dm_ready) begin
          w_freeze = 1'b1;
          if (MEM_TIMEOUT == 1) begin
            w_next_state = HZ_ERROR;
          end else begin
            w_next_state    = HZ_MEM_WAIT;
            w_next_wait_cnt = 8'd1;
          end
        end
      end
      HZ_MEM_WAIT: begin
        // The ready cycle itself is not frozen: the pipeline advances with the data.
        if (dm_ready) begin
          w_next_state    = HZ_RUN;
          w_next_wait_cnt = 8'd0;
        end else begin
          w_freeze = 1'b1;
          if (({1'b0, r_wait_cnt} + 9'd1) == TIMEOUT_LIM) begin
            w_next_state = HZ_ERROR;
          end else begin
            w_next_wait_cnt = r_wait_cnt + 8'd1;
          end
        end
      end
      HZ_ERROR: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_next_state    = HZ_RUN;
        w_next_wait_cnt = 8'd0;
      end
    endcase
  end

  assign w_load_use     = load_use_detect(EX_dm_read, EX_write_reg_1, ID_rs, ID_rt, ID_uses_rt);
  assign w_branch_eff   = !reset && !w_freeze && EX_branch_taken;
  assign w_load_use_eff = !reset && !w_freeze && !EX_branch_taken && w_load_use;

  always_comb begin
    w_ctrl = CTRL_RUN;
    if (reset) begin
      w_ctrl = CTRL_RESET;
    end else if (w_freeze) begin
      w_ctrl = CTRL_FREEZE;
    end else if (EX_branch_taken) begin
      w_ctrl = CTRL_BRANCH;
    end else if (w_load_use) begin
      w_ctrl = CTRL_LOAD_USE;
    end
  end

  assign pc_write_enable     = w_ctrl.pc_we;
  assign IF_ID_write_enable  = w_ctrl.if_id_we;
  assign IF_ID_flush         = w_ctrl.if_id_flush;
  assign ID_EX_flush         = w_ctrl.id_ex_flush;
  assign EX_MEM_write_enable = w_ctrl.ex_mem_we;
  assign MEM_WB_bubble       = w_ctrl.mem_wb_bubble;
  assign mem_stall           = w_ctrl.mem_stall;
  assign mem_timeout_error   = r_timeout_error;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = (!reset && w_freeze) || w_load_use_eff;
  assign w_flush_inc = w_branch_eff;

  hazard_sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (w_stall_inc),
    .count (stall_cycle_count)
  );

  hazard_sat_counter #(.WIDTH(STALL_CNT_W)) u_flush_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (w_flush_inc),
    .count (flush_count)
  );
`else
  logic w_unused_perf;

  assign w_unused_perf     = w_branch_eff ^ w_load_use_eff;
  assign stall_cycle_count = '0;
  assign flush_count       = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed self-checking bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

`ifdef HAZARD_PERF_COUNTERS_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  // {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_bubble, mem_stall}
  localparam logic [6:0] E_RUN = 7'b1100100;
  localparam logic [6:0] E_RST = 7'b0011010;
  localparam logic [6:0] E_LU  = 7'b0001100;
  localparam logic [6:0] E_BR  = 7'b1111100;
  localparam logic [6:0] E_FRZ = 7'b0000011;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  ID_rs, ID_rt, EX_write_reg_1;
  logic        ID_uses_rt, EX_dm_read, EX_branch_taken, MEM_dm_access, dm_ready;
  logic        pc_write_enable, IF_ID_write_enable, IF_ID_flush, ID_EX_flush;
  logic        EX_MEM_write_enable, MEM_WB_bubble, mem_stall, mem_timeout_error;
  logic [15:0] stall_cycle_count, flush_count;
  logic [6:0]  obs;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_controller #(.MEM_TIMEOUT(4), .STALL_CNT_W(16)) dut (
    .clock               (clock),
    .reset               (reset),
    .ID_rs               (ID_rs),
    .ID_rt               (ID_rt),
    .ID_uses_rt          (ID_uses_rt),
    .EX_write_reg_1      (EX_write_reg_1),
    .EX_dm_read          (EX_dm_read),
    .EX_branch_taken     (EX_branch_taken),
    .MEM_dm_access       (MEM_dm_access),
    .dm_ready            (dm_ready),
    .pc_write_enable     (pc_write_enable),
    .IF_ID_write_enable  (IF_ID_write_enable),
    .IF_ID_flush         (IF_ID_flush),
    .ID_EX_flush         (ID_EX_flush),
    .EX_MEM_write_enable (EX_MEM_write_enable),
    .MEM_WB_bubble       (MEM_WB_bubble),
    .mem_stall           (mem_stall),
    .mem_timeout_error   (mem_timeout_error),
    .stall_cycle_count   (stall_cycle_count),
    .flush_count         (flush_count)
  );

  always #5 clock = ~clock;

  assign obs = {pc_write_enable, IF_ID_write_enable, IF_ID_flush, ID_EX_flush,
                EX_MEM_write_enable, MEM_WB_bubble, mem_stall};

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0; EX_write_reg_1 = 5'd0;
    EX_dm_read = 1'b0; EX_branch_taken = 1'b0; MEM_dm_access = 1'b0; dm_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("reset_ctrl_comb", 32'(obs), 32'(E_RST));
    tick();
    chk("reset_ctrl_held", 32'(obs), 32'(E_RST));
    reset = 1'b0;
    #1;
    chk("post_reset_ctrl", 32'(obs), 32'(E_RUN));
    chk("post_reset_state", 32'(dut.r_state), 32'd0);
    chk("post_reset_err", 32'(mem_timeout_error), 32'd0);
    chk("post_reset_stall_cnt", 32'(stall_cycle_count), 32'd0);
    chk("post_reset_flush_cnt", 32'(flush_count), 32'd0);

    // load-use on rs
    EX_dm_read = 1'b1; EX_write_reg_1 = 5'd8; ID_rs = 5'd8;
    #1;
    chk("load_use_rs_ctrl", 32'(obs), 32'(E_LU));
    tick();
    idle_inputs();
    #1;
    chk("load_use_one_cycle", 32'(obs), 32'(E_RUN));
    chk("load_use_stall_cnt", 32'(stall_cycle_count), 32'(PERF * 1));

    // load into $zero and rt match without rt use
    EX_dm_read = 1'b1; EX_write_reg_1 = 5'd0; ID_rs = 5'd0;
    #1;
    chk("load_zero_no_stall", 32'(obs), 32'(E_RUN));
    EX_write_reg_1 = 5'd9; ID_rs = 5'd3; ID_rt = 5'd9; ID_uses_rt = 1'b0;
    #1;
    chk("rt_unused_no_stall", 32'(obs), 32'(E_RUN));
    ID_uses_rt = 1'b1;
    #1;
    chk("rt_used_stall", 32'(obs), 32'(E_LU));
    tick();
    idle_inputs();
    #1;
    chk("rt_stall_cnt", 32'(stall_cycle_count), 32'(PERF * 2));

    // taken branch overrides load-use
    EX_branch_taken = 1'b1; EX_dm_read = 1'b1; EX_write_reg_1 = 5'd8; ID_rs = 5'd8;
    #1;
    chk("branch_over_lu_ctrl", 32'(obs), 32'(E_BR));
    tick();
    idle_inputs();
    #1;
    chk("branch_ctrl_after", 32'(obs), 32'(E_RUN));
    chk("branch_flush_cnt", 32'(flush_count), 32'(PERF * 1));

    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("reset2_flush_cnt", 32'(flush_count), 32'd0);

    // memory wait: three not-ready cycles then ready
    MEM_dm_access = 1'b1; dm_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mem_wait_freeze", 32'(obs), 32'(E_FRZ));
      tick();
    end
    chk("mem_wait_state", 32'(dut.r_state), 32'd1);
    dm_ready = 1'b1;
    #1;
    chk("mem_ready_ctrl", 32'(obs), 32'(E_RUN));
    tick();
    idle_inputs();
    #1;
    chk("mem_ready_state", 32'(dut.r_state), 32'd0);
    chk("mem_wait_stall_cnt", 32'(stall_cycle_count), 32'(PERF * 3));
    chk("mem_wait_no_err", 32'(mem_timeout_error), 32'd0);

    // timeout with MEM_TIMEOUT=4
    MEM_dm_access = 1'b1; dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("timeout_freeze", 32'(obs), 32'(E_FRZ));
      chk("timeout_err_low", 32'(mem_timeout_error), 32'd0);
      tick();
    end
    chk("timeout_state", 32'(dut.r_state), 32'd2);
    chk("timeout_err_set", 32'(mem_timeout_error), 32'd1);
    dm_ready = 1'b1; EX_branch_taken = 1'b1;
    #1;
    chk("error_freeze_hold", 32'(obs), 32'(E_FRZ));
    tick();
    chk("error_err_sticky", 32'(mem_timeout_error), 32'd1);
    chk("error_stall_cnt", 32'(stall_cycle_count), 32'(PERF * 8));
    chk("error_flush_cnt", 32'(flush_count), 32'd0);
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("error_reset_clr", 32'(mem_timeout_error), 32'd0);
    chk("error_reset_state", 32'(dut.r_state), 32'd0);

    // reset in the middle of a memory wait
    MEM_dm_access = 1'b1; dm_ready = 1'b0;
    tick();
    tick();
    chk("midwait_state", 32'(dut.r_state), 32'd1);
    reset = 1'b1;
    #1;
    chk("midwait_reset_ctrl", 32'(obs), 32'(E_RST));
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("midwait_state_run", 32'(dut.r_state), 32'd0);
    chk("midwait_ctrl_run", 32'(obs), 32'(E_RUN));
    chk("midwait_stall_cnt", 32'(stall_cycle_count), 32'd0);
    chk("midwait_err", 32'(mem_timeout_error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage Mini-MIPS pipeline.
- Drives the write-enable, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three hazards:
  - load-use: 1-cycle stall;
  - taken branch: flush;
  - multi-cycle data-memory access: whole-pipeline freeze, with a timeout error.
- Sits beside the datapath in the top-level CPU; the datapath holds no hazard logic of its own.

Parameters:
- MEM_TIMEOUT, 15: consecutive not-ready data-memory cycles tolerated before the error state; legal range 1..255.
- STALL_CNT_W, 16: width of the performance counters.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- ID_rs  in  5  source register 1 of the instruction in ID
- ID_rt  in  5  source register 2 of the instruction in ID
- ID_uses_rt  in  1  ID instruction reads rt
- EX_write_reg_1  in  5  destination register of the instruction in EX
- EX_dm_read  in  1  EX instruction is a load
- EX_branch_taken  in  1  branch in EX resolved taken
- MEM_dm_access  in  1  MEM instruction accesses data memory (load or store)
- dm_ready  in  1  data memory completes the access this cycle
- pc_write_enable  out  1  PC update allowed
- IF_ID_write_enable  out  1  IF/ID capture allowed
- IF_ID_flush  out  1  IF/ID loads a NOP
- ID_EX_flush  out  1  ID/EX loads a bubble (all control bits 0)
- EX_MEM_write_enable  out  1  EX/MEM capture allowed
- MEM_WB_bubble  out  1  MEM/WB captures MEM_rm_write_enable as 0
- mem_stall  out  1  pipeline frozen for data memory
- mem_timeout_error  out  1  sticky error flag
- stall_cycle_count  out  STALL_CNT_W  stall cycles, saturating
- flush_count  out  STALL_CNT_W  branch flushes, saturating

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - While reset=1, outputs are combinationally forced to:
    - all write enables 0;
    - IF_ID_flush, ID_EX_flush and MEM_WB_bubble 1;
    - mem_stall 0.
  - On the first edge with reset=1:
    - state←RUN, wait_cnt←0;
    - counters←0, mem_timeout_error←0.
- State machine, states RUN, MEM_WAIT, ERROR:
  - freeze = (RUN & MEM_dm_access & !dm_ready) | (MEM_WAIT & !dm_ready) | ERROR.
  - RUN:
    - MEM_dm_access & !dm_ready → MEM_WAIT, wait_cnt←1.
    - If MEM_TIMEOUT=1, go → ERROR instead.
  - MEM_WAIT:
    - dm_ready=1 → RUN, wait_cnt←0. The pipeline advances in the dm_ready cycle itself.
    - !dm_ready & wait_cnt+1==MEM_TIMEOUT → ERROR.
    - Otherwise wait_cnt++.
  - ERROR: held until reset; mem_timeout_error=1 (registered, set on entry).
- Freeze outputs:
  - pc_write_enable, IF_ID_write_enable and EX_MEM_write_enable are 0.
  - ID_EX_flush=0 (ID/EX holds via upstream freeze).
  - MEM_WB_bubble=1, mem_stall=1.
  - Branch and load-use are not evaluated.
- When not frozen:
  - load_use = EX_dm_read & EX_write_reg_1!=0 & (EX_write_reg_1==ID_rs | (ID_uses_rt & EX_write_reg_1==ID_rt)).
  - Taken branch (EX_branch_taken):
    - IF_ID_flush=1, ID_EX_flush=1, pc_write_enable=1;
    - load_use is ignored, because the dependent instruction is squashed.
  - Otherwise, load_use:
    - pc_write_enable=0, IF_ID_write_enable=0, ID_EX_flush=1.
    - Exactly 1 cycle: the next cycle the load is in MEM and forwarding covers it.
  - Otherwise: all write enables 1, no flush, no bubble.
- Priority: reset > freeze > branch > load-use.
- Output timing: all control outputs except mem_timeout_error are combinational from state and inputs, so there is zero-cycle latency to the pipeline registers.
- Counters:
  - stall_cycle_count increments on each cycle with freeze|load_use.
  - flush_count increments on each taken-branch cycle.
  - Both saturate at all-ones.

Optional Feature:
- HAZARD_PERF_COUNTERS_EN:
  - Defined: stall_cycle_count and flush_count are implemented as above.
  - Undefined: both ports are tied to 0 and the counter flops are not instantiated.
  - Port list is identical in both builds.

Decomposition:
- Shared package mips_pipeline_pkg holds:
  - hazard state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2);
  - REG_ZERO=5'd0;
  - the NOP/bubble control constants.
- One sub-module: hazard_sat_counter (width parameter; inc, clear; saturating). Instantiated twice under HAZARD_PERF_COUNTERS_EN.

Test Plan:
- Load-use: EX_dm_read=1, EX_write_reg_1=5'd8, ID_rs=5'd8 → exactly 1 cycle of pc_write_enable=0, IF_ID_write_enable=0, ID_EX_flush=1; stall_cycle_count=1.
- Load to $zero: EX_write_reg_1=0=ID_rs → no stall. ID_rt match with ID_uses_rt=0 → no stall.
- Branch + load-use same cycle: EX_branch_taken=1, load_use true → IF_ID_flush=ID_EX_flush=1, pc_write_enable=1; flush_count=1.
- Memory wait: MEM_dm_access=1, dm_ready low 3 cycles then high → mem_stall=1 for 3 cycles, MEM_WB_bubble=1, EX_MEM_write_enable=0; 4th cycle all enables 1; state RUN.
- Timeout with MEM_TIMEOUT=4 and dm_ready never asserted → ERROR after 4th not-ready cycle; mem_timeout_error=1 from cycle 5; freeze persists; reset clears it.
- Reset mid-MEM_WAIT: reset=1 for 1 cycle → next cycle RUN, counters 0, mem_stall=0.
